// File: rtl/pwm_dekoder_if.sv
// PWM decoder signal bundle: PWM line in, decoded level/strobe/no-signal out.
// master = PWM source / level consumer, slave = the decoder.
interface pwm_dekoder_if;
  logic       in_pwm;
  logic [1:0] out_poziom;
  logic       out_wazny;
  logic       out_brak_sygnalu;

  modport master (
    output in_pwm,
    input  out_poziom,
    input  out_wazny,
    input  out_brak_sygnalu
  );

  modport slave (
    input  in_pwm,
    output out_poziom,
    output out_wazny,
    output out_brak_sygnalu
  );
endinterface

// File: rtl/pwm_dekoder.sv
// Measures an asynchronous PWM line and recovers the 2-bit brightness code.
// Optional PWM_DEKODER_FILTR_EN: level changes need two agreeing measurements.
module pwm_dekoder #(
  parameter int unsigned rozmiar_licznika = 16,
  parameter int unsigned limit_okresu     = 2**(rozmiar_licznika+1),
  parameter int unsigned min_okres        = 16
) (
  input  logic         in_clk,
  input  logic         in_reset_n,
  pwm_dekoder_if.slave bus
);

  localparam int unsigned CW = rozmiar_licznika + 2;
  localparam int unsigned PW = rozmiar_licznika + 10;
  localparam logic [CW-1:0] LIMIT     = CW'(limit_okresu);
  localparam logic [CW-1:0] MIN_OKRES = CW'(min_okres);

  typedef enum logic [1:0] {CZEKAJ, POMIAR, STALY_WYS} stan_t;

  stan_t         stan, stan_nast;
  logic          s1, s2, s3;
  logic          zbocze_nar, zbocze_opad;
  logic [CW-1:0] okres, okres_nast;
  logic [CW-1:0] wysoki, wysoki_nast;
  logic [CW-1:0] niski, niski_nast;
  logic          limit_wys, limit_nis;
  logic [1:0]    klasa;
  logic [1:0]    poziom, poziom_nast;
  logic          wazny, wazny_nast;
  logic          brak, brak_nast;
`ifdef PWM_DEKODER_FILTR_EN
  logic [1:0]    kand, kand_nast;
  logic          kand_ok, kand_ok_nast;
`endif

  function automatic logic [CW-1:0] nasyc(input logic [CW-1:0] v, input logic en);
    return (en && v != LIMIT) ? v + CW'(1) : v;
  endfunction

  assign zbocze_nar  = s2 & ~s3;
  assign zbocze_opad = ~s2 & s3;

  // Counters; the rising-edge cycle itself is the first cycle of the new period.
  always_comb begin
    okres_nast  = nasyc(okres, 1'b1);
    wysoki_nast = nasyc(wysoki, s2);
    niski_nast  = s2 ? '0 : nasyc(niski, 1'b1);
    limit_wys   = s2 && (wysoki != LIMIT) && (wysoki_nast == LIMIT);
    limit_nis   = (niski != LIMIT) && (niski_nast == LIMIT);
    if (zbocze_nar) begin
      okres_nast  = CW'(1);
      wysoki_nast = CW'(1);
      limit_wys   = 1'b0;
    end
  end

  // Division-free duty classification against Q8 geometric midpoints.
  always_comb begin
    logic [PW-1:0] w_q8, p_ext;
    w_q8  = PW'(wysoki) << 8;
    p_ext = PW'(okres);
    if (w_q8 >= p_ext * PW'(174))     klasa = 2'b11;
    else if (w_q8 >= p_ext * PW'(81)) klasa = 2'b10;
    else if (w_q8 >= p_ext * PW'(38)) klasa = 2'b01;
    else                              klasa = 2'b00;
  end

  always_comb begin
    stan_nast   = stan;
    poziom_nast = poziom;
    wazny_nast  = 1'b0;
    brak_nast   = brak;
`ifdef PWM_DEKODER_FILTR_EN
    kand_nast    = kand;
    kand_ok_nast = kand_ok;
`endif
    unique case (stan)
      CZEKAJ: begin
        if (zbocze_nar) begin
          stan_nast = POMIAR;
        end else if (limit_nis) begin
          poziom_nast = 2'b00;
          brak_nast   = 1'b1;
          wazny_nast  = 1'b1;
`ifdef PWM_DEKODER_FILTR_EN
          kand_ok_nast = 1'b0;
`endif
        end
      end
      POMIAR: begin
        if (zbocze_nar) begin
          if (okres >= MIN_OKRES) begin
            brak_nast = 1'b0;
`ifdef PWM_DEKODER_FILTR_EN
            if (klasa == poziom) begin
              kand_ok_nast = 1'b0;
            end else if (kand_ok && kand == klasa) begin
              poziom_nast  = klasa;
              wazny_nast   = 1'b1;
              kand_ok_nast = 1'b0;
            end else begin
              kand_nast    = klasa;
              kand_ok_nast = 1'b1;
            end
            if (brak) wazny_nast = 1'b1;
`else
            poziom_nast = klasa;
            wazny_nast  = 1'b1;
`endif
          end
        end else if (limit_wys) begin
          poziom_nast = 2'b11;
          brak_nast   = 1'b0;
          wazny_nast  = 1'b1;
          stan_nast   = STALY_WYS;
`ifdef PWM_DEKODER_FILTR_EN
          kand_ok_nast = 1'b0;
`endif
        end else if (limit_nis) begin
          poziom_nast = 2'b00;
          brak_nast   = 1'b1;
          wazny_nast  = 1'b1;
          stan_nast   = CZEKAJ;
`ifdef PWM_DEKODER_FILTR_EN
          kand_ok_nast = 1'b0;
`endif
        end
      end
      STALY_WYS: begin
        if (zbocze_opad) stan_nast = CZEKAJ;
      end
      default: stan_nast = CZEKAJ;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (!in_reset_n) begin
      stan   <= CZEKAJ;
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      okres  <= '0;
      wysoki <= '0;
      niski  <= '0;
      poziom <= 2'b00;
      wazny  <= 1'b0;
      brak   <= 1'b0;
`ifdef PWM_DEKODER_FILTR_EN
      kand    <= 2'b00;
      kand_ok <= 1'b0;
`endif
    end else begin
      stan   <= stan_nast;
      s1     <= bus.in_pwm;
      s2     <= s1;
      s3     <= s2;
      okres  <= okres_nast;
      wysoki <= wysoki_nast;
      niski  <= niski_nast;
      poziom <= poziom_nast;
      wazny  <= wazny_nast;
      brak   <= brak_nast;
`ifdef PWM_DEKODER_FILTR_EN
      kand    <= kand_nast;
      kand_ok <= kand_ok_nast;
`endif
    end
  end

  assign bus.out_poziom       = poziom;
  assign bus.out_wazny        = wazny;
  assign bus.out_brak_sygnalu = brak;

endmodule

// File: tb/tb_pwm_dekoder.sv
// Directed bench for pwm_dekoder with rozmiar_licznika=8 (period 256, timeout 512).
module tb_pwm_dekoder;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_strobe;
  logic lat1, lat2;
  logic brak_probe;

  pwm_dekoder_if bus ();

  pwm_dekoder #(.rozmiar_licznika(8)) dut (
    .in_clk     (clk),
    .in_reset_n (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One PWM period: high for 'wys' cycles then low; counts strobes seen.
  task automatic okres(input int wys, input int per);
    for (int i = 0; i < per; i++) begin
      bus.in_pwm = (i < wys);
      @(negedge clk);
      if (bus.out_wazny) n_strobe++;
      if (i == 1) lat1 = bus.out_wazny;
      if (i == 2) lat2 = bus.out_wazny;
    end
  endtask

  task automatic blok(input int wys, input int n);
    n_strobe = 0;
    for (int i = 0; i < n; i++) okres(wys, 256);
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.in_pwm = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_poziom", 32'(bus.out_poziom), 0);
    check("reset_wazny", 32'(bus.out_wazny), 0);
    check("reset_brak", 32'(bus.out_brak_sygnalu), 0);
    rst_n = 1'b1;

    blok(119, 4);
    check("d119_strobes", 32'(n_strobe), 3);
    check("d119_poziom", 32'(bus.out_poziom), 2);
    check("d119_brak", 32'(bus.out_brak_sygnalu), 0);

    blok(26, 1);
    check("lat_edge1", 32'(lat1), 0);
    check("lat_edge2", 32'(lat2), 1);
    blok(26, 4);
    check("d26_strobes", 32'(n_strobe), 4);
    check("d26_poziom", 32'(bus.out_poziom), 0);

    blok(38, 4);
    check("d38_poziom", 32'(bus.out_poziom), 1);
    blok(37, 4);
    check("d37_poziom", 32'(bus.out_poziom), 0);
    blok(55, 4);
    check("d55_strobes", 32'(n_strobe), 4);
    check("d55_poziom", 32'(bus.out_poziom), 1);

    n_strobe = 0;
    okres(600, 700);
    check("hi_strobes", 32'(n_strobe), 2);
    check("hi_poziom", 32'(bus.out_poziom), 3);
    check("hi_brak", 32'(bus.out_brak_sygnalu), 0);
    blok(55, 1);
    check("hi_first_rise", 32'(bus.out_poziom), 3);
    blok(55, 2);
    check("hi_after_strobes", 32'(n_strobe), 2);
    check("hi_after_poziom", 32'(bus.out_poziom), 1);

    // Reset in the middle of a high phase.
    bus.in_pwm = 1'b1;
    repeat (20) @(negedge clk);
    rst_n      = 1'b0;
    bus.in_pwm = 1'b0;
    @(negedge clk);
    check("mid_rst_poziom", 32'(bus.out_poziom), 0);
    check("mid_rst_wazny", 32'(bus.out_wazny), 0);
    check("mid_rst_brak", 32'(bus.out_brak_sygnalu), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    n_strobe = 0;
    brak_probe = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.out_wazny) n_strobe++;
      if (i == 499) brak_probe = bus.out_brak_sygnalu;
    end
    check("lo_early_brak", 32'(brak_probe), 0);
    check("lo_strobes", 32'(n_strobe), 1);
    check("lo_brak", 32'(bus.out_brak_sygnalu), 1);
    check("lo_poziom", 32'(bus.out_poziom), 0);

    blok(119, 1);
    check("lo_first_brak", 32'(bus.out_brak_sygnalu), 1);
    blok(119, 2);
    check("lo_after_strobes", 32'(n_strobe), 2);
    check("lo_after_poziom", 32'(bus.out_poziom), 2);
    check("lo_after_brak", 32'(bus.out_brak_sygnalu), 0);

    // Short glitches: only the first rise closes a valid 119/256 period.
    n_strobe = 0;
    for (int i = 0; i < 8; i++) okres(3, 10);
    check("gl_strobes", 32'(n_strobe), 1);
    check("gl_poziom", 32'(bus.out_poziom), 2);
    blok(26, 3);
    check("gl_after_strobes", 32'(n_strobe), 2);
    check("gl_after_poziom", 32'(bus.out_poziom), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
